proc_itr_ctrl: RTL

- Interrupt controller for a proc_fx processor.
- Collects NSRC synchronous event lines, latches rising edges as pending requests, applies a software mask and picks one request by fixed priority (lowest index wins).
- Drives the core's itr line and handles the cause-read / acknowledge handshake through the processor's I/O bus.
- Passes all other io_in traffic from the external device mux through unchanged.

---
 rtl/proc_itr_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/proc_itr_ctrl.sv
// proc_itr_ctrl: interrupt controller for the proc_fx core.
// Latches rising edges of NSRC event lines as pending requests, masks them,
// picks the lowest-index eligible request and runs the itr / cause-read /
// acknowledge handshake over the processor I/O bus. Non-controller read
// addresses pass the external device data straight through.
module proc_itr_ctrl #(
  parameter int NUBITS     = 16,
  parameter int NSRC       = 4,
  parameter int NUIOIN     = 2,
  parameter int NUIOOU     = 2,
  parameter int ADDR_CAUSE = 0,
  parameter int ADDR_STAT  = 1,
  parameter int ADDR_MASK  = 0,
  parameter int ADDR_ACK   = 1,
  // Derived widths; a single address still needs a one-bit port.
  parameter int IA_W = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  parameter int OA_W = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src,
  input  logic [NUBITS-1:0] io_out,
  input  logic [OA_W-1:0]   addr_out,
  input  logic              out_en,
  input  logic [IA_W-1:0]   addr_in,
  input  logic              req_in,
  input  logic [NUBITS-1:0] io_in_dev,
  output logic [NUBITS-1:0] io_in,
  output logic              itr
);

  localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [IA_W-1:0] A_CAUSE = IA_W'(ADDR_CAUSE);
  localparam logic [IA_W-1:0] A_STAT  = IA_W'(ADDR_STAT);
  localparam logic [OA_W-1:0] A_MASK  = OA_W'(ADDR_MASK);
  localparam logic [OA_W-1:0] A_ACK   = OA_W'(ADDR_ACK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] ovf;
  logic [NSRC-1:0] mask;
  logic [CW-1:0]   cause;

  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] pend_clr;
  logic [CW-1:0]   sel;
  logic            cause_rd;
  logic            stat_rd;
  logic            ack_wr;
  logic            mask_wr;

  // Only the low NSRC bits of a mask write carry information.
  logic unused_io_out_hi;
  assign unused_io_out_hi = ^io_out[NUBITS-1:NSRC];

  // Fixed priority: the lowest set index wins.
  function automatic logic [CW-1:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  // Request qualification and bus decode.
  always_comb begin
    edge_det = src & ~src_q;
    eligible = pending & mask;
    sel      = lowest_idx(eligible);
    cause_rd = req_in && (addr_in == A_CAUSE) && (state == ASSERT);
    stat_rd  = req_in && (addr_in == A_STAT);
    ack_wr   = out_en && (addr_out == A_ACK) && (state == SERVICE);
    mask_wr  = out_en && (addr_out == A_MASK);
    pend_clr = '0;
    if (cause_rd) pend_clr[cause] = 1'b1;
  end

  // Read mux toward the core: cause, status, or external device data.
  always_comb begin
    if (addr_in == A_CAUSE)
      io_in = NUBITS'(cause);
    else if (addr_in == A_STAT)
      io_in = NUBITS'({ovf, pending});
    else
      io_in = io_in_dev;
  end

  // Edge history, pending/overflow latches and the mask register; sets win over clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      pending <= '0;
      ovf     <= '0;
      mask    <= '0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~pend_clr) | edge_det;
      ovf     <= (stat_rd ? '0 : ovf) | (edge_det & pending);
      if (mask_wr) mask <= io_out[NSRC-1:0];
    end
  end

  // Handshake FSM; cause is frozen from IDLE->ASSERT until the next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cause <= '0;
      itr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            cause <= sel;
            state <= ASSERT;
            itr   <= 1'b1;
          end
        end
        ASSERT: begin
          if (cause_rd) begin
            state <= SERVICE;
            itr   <= 1'b0;
          end
        end
        SERVICE: begin
          if (ack_wr) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          itr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
